ldl_crc32_dn_check: RTL and testbench

Parametrised Ethernet-style CRC-32 frame checker that accepts NB bytes per beat and tracks frame boundaries with sof/eof and a byte count on the last beat. It reports a per-frame pass/fail pulse plus saturating frame and error statistics. It is the multi-byte successor to the single-byte CRC-32 checker and sits at the receive MAC/PCS boundary, after the data path and before frame filtering.

---
 rtl/ldl_crc32_pkg.sv | 22 ++
 rtl/ldl_crc32_d8.sv | 24 ++
 rtl/ldl_crc32_dn_check.sv | 125 ++++++++++++
 tb/tb_ldl_crc32_dn_check.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldl_crc32_pkg.sv
// Shared CRC-32 constants, byte bit-reversal helper and frame-checker state type.
package ldl_crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  // Wire order is LSB first, while the byte step shifts MSB first.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ldl_crc32_d8.sv
// Combinational CRC-32 byte step: shifts data[7] first through the non-reflected register.
module ldl_crc32_d8
  import ldl_crc32_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (acc[31] ^ data[i]) begin
        acc = {acc[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        acc = {acc[30:0], 1'b0};
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/ldl_crc32_dn_check.sv
// NB-bytes-per-beat Ethernet CRC-32 frame checker with sof/eof framing,
// per-frame pass/fail pulse and saturating frame/error statistics.
module ldl_crc32_dn_check
  import ldl_crc32_pkg::*;
#(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*NB-1:0]       data,
  input  logic                  valid,
  input  logic                  sof,
  input  logic                  eof,
  input  logic [$clog2(NB):0]   mod,
  input  logic                  stat_clr,
  output logic                  done,
  output logic                  err,
  output logic                  proto_err,
  output logic                  in_frame,
  output logic [CNT_W-1:0]      frm_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  state_e             state_q;
  logic [31:0]        crc_q;
  logic               done_q;
  logic               err_q;
  logic               perr_q;
  logic [CNT_W-1:0]   frm_cnt_q;
  logic [CNT_W-1:0]   frm_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   err_cnt_d;

  logic [31:0]        crcBase;
  logic [31:0]        crcEof;
  logic [31:0]        tap [NB+1];
  logic [7:0]         revByte [NB];
  logic [1:0]         errInc;
  logic [CNT_W:0]     frmSum;
  logic [CNT_W:0]     errSum;

  // A sof beat always restarts from init, also when it aborts a running frame.
  assign crcBase = (state_q == IN_FRAME && !sof) ? crc_q : CRC32_INIT;
  assign tap[0]  = crcBase;

  for (genvar g = 0; g < NB; g++) begin : g_chain
    assign revByte[g] = bitrev8(data[8*g +: 8]);
    ldl_crc32_d8 u_step (
      .data    (revByte[g]),
      .crc_in  (tap[g]),
      .crc_out (tap[g+1])
    );
  end

  always_comb begin
    crcEof = tap[NB];
    for (int i = 1; i < NB; i++) begin
      if (int'(mod) == i) begin
        crcEof = tap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= CRC32_INIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      perr_q <= 1'b0;
      if (valid) begin
        if (state_q == IN_FRAME && sof) begin
          perr_q <= 1'b1;
        end
        if (state_q == IDLE && !sof) begin
          perr_q <= 1'b1;
        end else if (eof) begin
          done_q  <= 1'b1;
          err_q   <= (crcEof != CRC32_RESIDUE);
          crc_q   <= CRC32_INIT;
          state_q <= IDLE;
        end else begin
          crc_q   <= tap[NB];
          state_q <= IN_FRAME;
        end
      end
    end
  end

  // A sof+eof abort can bump the error counter by two in one cycle.
  assign errInc = {1'b0, done_q & err_q} + {1'b0, perr_q};
  assign frmSum = {1'b0, frm_cnt_q} + (CNT_W+1)'(done_q);
  assign errSum = {1'b0, err_cnt_q} + (CNT_W+1)'(errInc);

  always_comb begin
    frm_cnt_d = frmSum[CNT_W] ? {CNT_W{1'b1}} : frmSum[CNT_W-1:0];
    err_cnt_d = errSum[CNT_W] ? {CNT_W{1'b1}} : errSum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (stat_clr) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign proto_err = perr_q;
  assign in_frame  = (state_q == IN_FRAME);
  assign frm_cnt   = frm_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ldl_crc32_dn_check.sv
// Directed bench for ldl_crc32_dn_check: four builds (NB=4, NB=4/CNT_W=4, NB=1, NB=8)
// driven from a frame table plus hand-written abort, drop, saturation and reset sequences.
module tb_ldl_crc32_dn_check;

  logic        clk;
  logic        rst_n;
  logic [3:0]  validV, sofV, eofV, clrV;
  logic [31:0] data0, data1;
  logic [7:0]  data2;
  logic [63:0] data3;
  logic [2:0]  mod0, mod1;
  logic [0:0]  mod2;
  logic [3:0]  mod3;
  logic [3:0]  doneV, errV, perrV, infV;
  logic [15:0] frm0, err0, frm2, err2, frm3, err3;
  logic [3:0]  frm1, err1;

  int testsRun    = 0;
  int testsFailed = 0;
  int expFrm  [4];
  int expErrC [4];
  byte unsigned frameQ[$];

  typedef struct {
    string name;
    int    dutSel;
    int    payLen;
    int    flipIdx;
    bit    bubbles;
    bit    garbage;
    bit    useMod0;
    bit    expErr;
  } vec_t;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ldl_crc32_dn_check #(.NB(4), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .data(data0), .valid(validV[0]), .sof(sofV[0]), .eof(eofV[0]),
    .mod(mod0), .stat_clr(clrV[0]), .done(doneV[0]), .err(errV[0]), .proto_err(perrV[0]),
    .in_frame(infV[0]), .frm_cnt(frm0), .err_cnt(err0));

  ldl_crc32_dn_check #(.NB(4), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .valid(validV[1]), .sof(sofV[1]), .eof(eofV[1]),
    .mod(mod1), .stat_clr(clrV[1]), .done(doneV[1]), .err(errV[1]), .proto_err(perrV[1]),
    .in_frame(infV[1]), .frm_cnt(frm1), .err_cnt(err1));

  ldl_crc32_dn_check #(.NB(1), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .data(data2), .valid(validV[2]), .sof(sofV[2]), .eof(eofV[2]),
    .mod(mod2), .stat_clr(clrV[2]), .done(doneV[2]), .err(errV[2]), .proto_err(perrV[2]),
    .in_frame(infV[2]), .frm_cnt(frm2), .err_cnt(err2));

  ldl_crc32_dn_check #(.NB(8), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .data(data3), .valid(validV[3]), .sof(sofV[3]), .eof(eofV[3]),
    .mod(mod3), .stat_clr(clrV[3]), .done(doneV[3]), .err(errV[3]), .proto_err(perrV[3]),
    .in_frame(infV[3]), .frm_cnt(frm3), .err_cnt(err3));

  function automatic int nbOf(input int which);
    case (which)
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int satInc(input int which, input int v, input int inc);
    int mx = (which == 1) ? 15 : 65535;
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  // Reference CRC-32 in the reflected (LSB-first) form, used only to generate FCS bytes.
  function automatic logic [31:0] crcRef(input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, frameQ[i]};
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic buildFrame(input int payLen, input int flipIdx);
    logic [31:0] fcs;
    frameQ.delete();
    for (int i = 0; i < payLen; i++) frameQ.push_back(8'(8'h31 + i));
    fcs = crcRef(payLen);
    for (int i = 0; i < 4; i++) frameQ.push_back(fcs[8*i +: 8]);
    if (flipIdx >= 0) frameQ[flipIdx] = frameQ[flipIdx] ^ 8'h01;
  endtask

  function automatic logic [63:0] beatOf(input int nb, input int b, input bit garbage);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) begin
      int idx = b * nb + i;
      if (idx < frameQ.size()) v[8*i +: 8] = frameQ[idx];
      else if (garbage)        v[8*i +: 8] = 8'hA5;
    end
    return v;
  endfunction

  function automatic int modOf(input int nb, input int b, input bit useMod0);
    int rem = frameQ.size() - b * nb;
    if (rem >= nb) return useMod0 ? 0 : nb;
    return rem;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic driveIdle();
    validV = '0;
    sofV   = '0;
    eofV   = '0;
  endtask

  task automatic driveBeat(input int which, input logic [63:0] beat, input bit s, input bit e, input int m);
    driveIdle();
    validV[which] = 1'b1;
    sofV[which]   = s;
    eofV[which]   = e;
    case (which)
      0:       begin data0 = beat[31:0]; mod0 = 3'(m); end
      1:       begin data1 = beat[31:0]; mod1 = 3'(m); end
      2:       begin data2 = beat[7:0];  mod2 = 1'(m); end
      default: begin data3 = beat;       mod3 = 4'(m); end
    endcase
  endtask

  task automatic sampleOut(input int which, output logic d, output logic e, output logic p,
                           output logic inf, output logic [15:0] f, output logic [15:0] ec);
    d = doneV[which]; e = errV[which]; p = perrV[which]; inf = infV[which];
    case (which)
      0:       begin f = frm0;          ec = err0;          end
      1:       begin f = {12'h0, frm1}; ec = {12'h0, err1}; end
      2:       begin f = frm2;          ec = err2;          end
      default: begin f = frm3;          ec = err3;          end
    endcase
  endtask

  task automatic checkCycle(input int which, input string tag, input bit expDone, input bit expErr, input bit expPerr);
    logic d, e, p, inf;
    logic [15:0] f, ec;
    sampleOut(which, d, e, p, inf, f, ec);
    checkOutput({tag, ".done"}, 64'(d), 64'(expDone));
    checkOutput({tag, ".proto_err"}, 64'(p), 64'(expPerr));
    if (expDone) checkOutput({tag, ".err"}, 64'(e), 64'(expErr));
  endtask

  task automatic checkCounters(input int which, input string tag);
    logic d, e, p, inf;
    logic [15:0] f, ec;
    sampleOut(which, d, e, p, inf, f, ec);
    checkOutput({tag, ".frm_cnt"}, 64'(f), 64'(expFrm[which]));
    checkOutput({tag, ".err_cnt"}, 64'(ec), 64'(expErrC[which]));
  endtask

  task automatic checkInFrame(input int which, input string tag, input bit expInf);
    checkOutput({tag, ".in_frame"}, 64'(infV[which]), 64'(expInf));
  endtask

  // Sends frameQ as back-to-back beats (optionally with one bubble between beats).
  task automatic applyStimulus(input int which, input string tag, input bit bubbles,
                               input bit garbage, input bit useMod0, input bit expErr);
    int nb     = nbOf(which);
    int nBeats = (frameQ.size() + nb - 1) / nb;
    for (int b = 0; b < nBeats; b++) begin
      if (bubbles && b > 0) begin
        @(negedge clk);
        checkCycle(which, {tag, ".bub"}, 1'b0, 1'b0, 1'b0);
        driveIdle();
      end
      @(negedge clk);
      if (b > 0) checkCycle(which, {tag, ".mid"}, 1'b0, 1'b0, 1'b0);
      driveBeat(which, beatOf(nb, b, garbage), b == 0, b == nBeats - 1, modOf(nb, b, useMod0));
    end
    @(negedge clk);
    checkCycle(which, {tag, ".end"}, 1'b1, expErr, 1'b0);
    driveIdle();
    expFrm[which]  = satInc(which, expFrm[which], 1);
    expErrC[which] = satInc(which, expErrC[which], int'(expErr));
    @(negedge clk);
    checkCycle(which, {tag, ".after"}, 1'b0, 1'b0, 1'b0);
    checkInFrame(which, tag, 1'b0);
    checkCounters(which, tag);
  endtask

  task automatic addVec(input string name, input int dutSel, input int payLen, input int flipIdx,
                        input bit bubbles, input bit garbage, input bit useMod0, input bit expErr);
    vec_t v;
    v.name = name; v.dutSel = dutSel; v.payLen = payLen; v.flipIdx = flipIdx;
    v.bubbles = bubbles; v.garbage = garbage; v.useMod0 = useMod0; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    driveIdle();
    clrV  = '0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    mod0  = '0; mod1 = '0; mod2 = '0; mod3 = '0;
    for (int i = 0; i < 4; i++) begin expFrm[i] = 0; expErrC[i] = 0; end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkCycle(i, $sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("reset%0d.err", i), 64'(errV[i]), 64'd0);
      checkInFrame(i, $sformatf("reset%0d", i), 1'b0);
      checkCounters(i, $sformatf("reset%0d", i));
    end
    rst_n = 1'b1;

    addVec("good9",    0, 9,  -1, 0, 0, 0, 0);
    addVec("flip5",    0, 9,   5, 0, 0, 0, 1);
    addVec("bubbles",  0, 9,  -1, 1, 0, 0, 0);
    addVec("len8mod0", 0, 8,  -1, 0, 0, 1, 0);
    addVec("garbage",  0, 9,  -1, 0, 1, 0, 0);
    addVec("len3",     0, 3,  -1, 0, 1, 0, 0);
    addVec("single",   0, 0,  -1, 0, 0, 1, 0);
    addVec("fcsflip",  0, 1,   4, 0, 0, 0, 1);
    addVec("nb1good",  2, 9,  -1, 0, 0, 0, 0);
    addVec("nb1bub",   2, 9,   5, 1, 0, 0, 1);
    addVec("nb8good",  3, 9,  -1, 0, 1, 0, 0);
    addVec("nb8bub",   3, 9,  -1, 1, 0, 0, 0);
    addVec("nb8mod0",  3, 12, -1, 0, 0, 1, 0);
    foreach (vecs[i]) begin
      buildFrame(vecs[i].payLen, vecs[i].flipIdx);
      applyStimulus(vecs[i].dutSel, vecs[i].name, vecs[i].bubbles, vecs[i].garbage,
                    vecs[i].useMod0, vecs[i].expErr);
    end

    // Beat without sof while idle is dropped with a proto_err pulse.
    @(negedge clk);
    driveBeat(0, 64'h0, 1'b0, 1'b0, 4);
    @(negedge clk);
    checkCycle(0, "drop", 1'b0, 1'b0, 1'b1);
    driveIdle();
    expErrC[0] = satInc(0, expErrC[0], 1);
    @(negedge clk);
    checkCycle(0, "drop.after", 1'b0, 1'b0, 1'b0);
    checkInFrame(0, "drop", 1'b0);
    checkCounters(0, "drop");

    // sof after two beats aborts the frame; the restarted frame must still pass.
    buildFrame(9, -1);
    @(negedge clk); driveBeat(0, beatOf(4, 0, 0), 1'b1, 1'b0, 4);
    @(negedge clk); checkCycle(0, "abort.b0", 1'b0, 1'b0, 1'b0); checkInFrame(0, "abort.b0", 1'b1);
    driveBeat(0, beatOf(4, 1, 0), 1'b0, 1'b0, 4);
    @(negedge clk); checkCycle(0, "abort.b1", 1'b0, 1'b0, 1'b0);
    driveBeat(0, beatOf(4, 0, 0), 1'b1, 1'b0, 4);
    @(negedge clk); checkCycle(0, "abort.sof", 1'b0, 1'b0, 1'b1); checkInFrame(0, "abort.sof", 1'b1);
    expErrC[0] = satInc(0, expErrC[0], 1);
    driveBeat(0, beatOf(4, 1, 0), 1'b0, 1'b0, 4);
    @(negedge clk); checkCycle(0, "abort.n1", 1'b0, 1'b0, 1'b0);
    driveBeat(0, beatOf(4, 2, 0), 1'b0, 1'b0, 4);
    @(negedge clk); checkCycle(0, "abort.n2", 1'b0, 1'b0, 1'b0);
    driveBeat(0, beatOf(4, 3, 0), 1'b0, 1'b1, 1);
    @(negedge clk); checkCycle(0, "abort.done", 1'b1, 1'b0, 1'b0);
    driveIdle();
    expFrm[0] = satInc(0, expFrm[0], 1);
    @(negedge clk); checkCycle(0, "abort.after", 1'b0, 1'b0, 1'b0);
    checkCounters(0, "abort");

    // Bad single-beat sof+eof frame aborting a running one: err_cnt gains two.
    @(negedge clk); driveBeat(0, beatOf(4, 0, 0), 1'b1, 1'b0, 4);
    @(negedge clk); checkCycle(0, "dbl.b0", 1'b0, 1'b0, 1'b0);
    driveBeat(0, 64'h0000_0000_0100_0000, 1'b1, 1'b1, 0);
    @(negedge clk); checkCycle(0, "dbl", 1'b1, 1'b1, 1'b1); checkInFrame(0, "dbl", 1'b0);
    driveIdle();
    expFrm[0]  = satInc(0, expFrm[0], 1);
    expErrC[0] = satInc(0, expErrC[0], 2);
    @(negedge clk); checkCycle(0, "dbl.after", 1'b0, 1'b0, 1'b0);
    checkCounters(0, "dbl");

    // 17 bad frames into the 4-bit counter build, then stat_clr during a done.
    for (int i = 0; i < 17; i++) begin
      buildFrame(9, 5);
      applyStimulus(1, $sformatf("sat%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("sat.err_cnt_ff", 64'(err1), 64'hF);
    checkOutput("sat.frm_cnt_ff", 64'(frm1), 64'hF);
    buildFrame(9, -1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      driveBeat(1, beatOf(4, b, 0), b == 0, b == 3, modOf(4, b, 0));
    end
    @(negedge clk);
    checkCycle(1, "clr.done", 1'b1, 1'b0, 1'b0);
    driveIdle();
    clrV[1] = 1'b1;
    @(negedge clk);
    clrV[1] = 1'b0;
    expFrm[1] = 0; expErrC[1] = 0;
    checkCounters(1, "clr");

    // Reset mid-frame: outputs clear asynchronously, the next frame is clean.
    buildFrame(9, -1);
    @(negedge clk); driveBeat(0, beatOf(4, 0, 0), 1'b1, 1'b0, 4);
    @(negedge clk); driveBeat(0, beatOf(4, 1, 0), 1'b0, 1'b0, 4);
    @(negedge clk); checkInFrame(0, "prerst", 1'b1);
    driveBeat(0, beatOf(4, 2, 0), 1'b0, 1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin expFrm[i] = 0; expErrC[i] = 0; end
    checkCycle(0, "asyncrst", 1'b0, 1'b0, 1'b0);
    checkInFrame(0, "asyncrst", 1'b0);
    checkCounters(0, "asyncrst");
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
    @(negedge clk);
    checkCycle(0, "postrst.idle", 1'b0, 1'b0, 1'b0);
    applyStimulus(0, "postrst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
